// File: rtl/jk_drv_pkg.sv
// rtl/jk_drv_pkg.sv - shared state encoding, JK excitation codes and JK next-state function
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            JK_HOLD: jk_next = q;
            JK_CLR:  jk_next = 1'b0;
            JK_SET:  jk_next = 1'b1;
            default: jk_next = ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_lowbit_select.sv
// rtl/jk_lowbit_select.sv - picks the lowest MAX_FLIPS set bits of rem, purely combinational
module jk_lowbit_select #(
    parameter int WIDTH     = 8,
    parameter int MAX_FLIPS = 2
) (
    input  logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] sel
);

    always_comb begin : pick
        int cnt;
        sel = '0;
        cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rem[i] && (cnt < MAX_FLIPS)) begin
                sel[i] = 1'b1;
                cnt    = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - walks a JK bank to a target word, MAX_FLIPS bits per cycle; JK_CHECK_EN adds q_fb check
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_FLIPS  = 2,
    parameter int USE_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] shadow_q,
    output logic             busy,
    output logic             done,
    input  logic [WIDTH-1:0] q_fb,
    output logic             mismatch
);

    state_e           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] tgt_reg;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] diff;

    jk_lowbit_select #(
        .WIDTH     (WIDTH),
        .MAX_FLIPS (MAX_FLIPS)
    ) u_sel (
        .rem (rem),
        .sel (sel)
    );

    assign diff      = tgt_data ^ shadow_q;
    assign rem_next  = rem & ~sel;
    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        j = '0;
        k = '0;
        if (state == DRIVE) begin
            if (USE_TOGGLE != 0) begin
                j = sel;
                k = sel;
            end else begin
                j = sel & tgt_reg;
                k = sel & ~tgt_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rem     <= '0;
            tgt_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_reg <= tgt_data;
                        rem     <= diff;
                        state   <= (diff != '0) ? DRIVE : DONE;
                    end
                end
                DRIVE: begin
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow follows the bank edge-for-edge: both see the same j/k and reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                shadow_q[i] <= jk_next(shadow_q[i], j[i], k[i]);
            end
        end
    end

`ifdef JK_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else if (q_fb != shadow_q) begin
            mismatch <= 1'b1;
        end
    end
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - table plus scoreboard bench for jk_excitation_driver, unit 0 encoded, unit 1 toggle
module tb_jk_excitation_driver;
    import jk_drv_pkg::*;

`ifdef JK_CHECK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] j;
        logic [7:0] k;
        logic       done;
    } rec_t;

    typedef struct packed {
        int         u;
        logic [7:0] tgt;
        int         low;
        logic [7:0] sh;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tv  [2];
    logic [7:0] td  [2];
    logic       rdy [2];
    logic [7:0] jj  [2];
    logic [7:0] kk  [2];
    logic [7:0] sq  [2];
    logic       bsy [2];
    logic       dn  [2];
    logic [7:0] qfb [2];
    logic       mm  [2];
    logic [7:0] bank[2];
    logic       ferr[2];
    logic [7:0] msh [2];

    rec_t sbq[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(8), .MAX_FLIPS(2), .USE_TOGGLE(0)) dut (
        .clk(clk), .reset(reset), .tgt_valid(tv[0]), .tgt_ready(rdy[0]), .tgt_data(td[0]),
        .j(jj[0]), .k(kk[0]), .shadow_q(sq[0]), .busy(bsy[0]), .done(dn[0]),
        .q_fb(qfb[0]), .mismatch(mm[0])
    );

    jk_excitation_driver #(.WIDTH(8), .MAX_FLIPS(2), .USE_TOGGLE(1)) dut_t (
        .clk(clk), .reset(reset), .tgt_valid(tv[1]), .tgt_ready(rdy[1]), .tgt_data(td[1]),
        .j(jj[1]), .k(kk[1]), .shadow_q(sq[1]), .busy(bsy[1]), .done(dn[1]),
        .q_fb(qfb[1]), .mismatch(mm[1])
    );

    // The JK register bank each driver is steering.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bank[0] <= 8'h00;
            bank[1] <= 8'h00;
        end else begin
            for (int u = 0; u < 2; u++)
                for (int b = 0; b < 8; b++)
                    bank[u][b] <= jk_next(bank[u][b], jj[u][b], kk[u][b]);
        end
    end

    assign qfb[0] = bank[0] ^ {7'b0, ferr[0]};
    assign qfb[1] = bank[1] ^ {7'b0, ferr[1]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] low2(input logic [7:0] r);
        logic [7:0] s;
        int c;
        s = 8'h00;
        c = 0;
        for (int i = 0; i < 8; i++)
            if (r[i] && c < 2) begin
                s[i] = 1'b1;
                c++;
            end
        return s;
    endfunction

    task automatic run_txn(input int u, input logic [7:0] tgt, input int exp_low, input logic [7:0] exp_sh);
        rec_t       r;
        logic [7:0] rem;
        logic [7:0] s;
        int         lowc;
        rem = tgt ^ msh[u];
        while (rem != 8'h00) begin
            s      = low2(rem);
            r.j    = (u == 1) ? s : (s & tgt);
            r.k    = (u == 1) ? s : (s & ~tgt);
            r.done = 1'b0;
            sbq.push_back(r);
            rem = rem & ~s;
        end
        r = '{j: 8'h00, k: 8'h00, done: 1'b1};
        sbq.push_back(r);

        @(negedge clk);
        chk("ready_before", rdy[u], 1);
        tv[u] = 1'b1;
        td[u] = tgt;
        @(negedge clk);
        tv[u] = 1'b0;
        td[u] = 8'($urandom);
        lowc  = 0;
        while (!rdy[u] && lowc < 20) begin
            lowc++;
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                r = sbq.pop_front();
                chk("j", jj[u], r.j);
                chk("k", kk[u], r.k);
                chk("done", dn[u], r.done);
                chk("busy", bsy[u], 1);
            end
            @(negedge clk);
        end
        chk("ready_low_cycles", lowc, exp_low);
        chk("sb_left", sbq.size(), 0);
        chk("shadow", sq[u], exp_sh);
        chk("bank", bank[u], exp_sh);
        chk("mismatch_clean", mm[u], 0);
        sbq.delete();
        msh[u] = tgt;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{u: 0, tgt: 8'h0F, low: 3, sh: 8'h0F};
        tbl[1] = '{u: 0, tgt: 8'hF0, low: 5, sh: 8'hF0};
        tbl[2] = '{u: 0, tgt: 8'hF0, low: 1, sh: 8'hF0};
        tbl[3] = '{u: 0, tgt: 8'hA5, low: 3, sh: 8'hA5};
        tbl[4] = '{u: 0, tgt: 8'h00, low: 3, sh: 8'h00};
        tbl[5] = '{u: 1, tgt: 8'hF0, low: 3, sh: 8'hF0};
        tbl[6] = '{u: 1, tgt: 8'h0F, low: 5, sh: 8'h0F};
        tbl[7] = '{u: 1, tgt: 8'h0F, low: 1, sh: 8'h0F};

        for (int u = 0; u < 2; u++) begin
            tv[u] = 1'b0; td[u] = 8'h00; ferr[u] = 1'b0; msh[u] = 8'h00;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", rdy[u], 1);
            chk("rst_busy", bsy[u], 0);
            chk("rst_done", dn[u], 0);
            chk("rst_shadow", sq[u], 0);
            chk("rst_j", jj[u], 0);
            chk("rst_k", kk[u], 0);
            chk("rst_mismatch", mm[u], 0);
        end

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].u, tbl[i].tgt, tbl[i].low, tbl[i].sh);

        // Reset during the second DRIVE cycle of 0x00 -> 0xFF aborts the walk.
        @(negedge clk);
        tv[0] = 1'b1; td[0] = 8'hFF;
        @(negedge clk);
        tv[0] = 1'b0;
        chk("abort_j1", jj[0], 8'h03);
        @(negedge clk);
        chk("abort_j2", jj[0], 8'h0C);
        reset = 1'b1;
        #1;
        chk("abort_ready", rdy[0], 1);
        chk("abort_busy", bsy[0], 0);
        chk("abort_shadow", sq[0], 0);
        chk("abort_j", jj[0], 0);
        chk("abort_k", kk[0], 0);
        @(negedge clk);
        reset = 1'b0;
        msh[0] = 8'h00; msh[1] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            chk("abort_no_done", dn[0], 0);
            @(negedge clk);
        end

        // Valid held through DONE is taken on the first IDLE cycle; data ignored while busy.
        tv[0] = 1'b1; td[0] = 8'h03;
        @(negedge clk);
        td[0] = 8'h83;
        chk("b2b_j1", jj[0], 8'h03);
        chk("b2b_k1", kk[0], 8'h00);
        @(negedge clk);
        chk("b2b_done1", dn[0], 1);
        chk("b2b_shadow1", sq[0], 8'h03);
        @(negedge clk);
        chk("b2b_idle_ready", rdy[0], 1);
        @(negedge clk);
        tv[0] = 1'b0;
        chk("b2b_busy2", bsy[0], 1);
        chk("b2b_j2", jj[0], 8'h80);
        chk("b2b_k2", kk[0], 8'h00);
        @(negedge clk);
        chk("b2b_done2", dn[0], 1);
        chk("b2b_shadow2", sq[0], 8'h83);

        // One-cycle feedback corruption on bit 0.
        @(negedge clk);
        ferr[0] = 1'b1;
        @(negedge clk);
        ferr[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("mismatch_sticky", mm[0], EXP_MM);
            chk("mismatch_other", mm[1], 0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mismatch_cleared", mm[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
